// File: rtl/uart_rx.sv
// 8-bit UART receiver with 16x oversampling, optional parity, a one-deep output
// buffer with valid/ready handshake, and sticky error flags.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | line idle, waiting for a tick with rxIn low
//  S_START  | confirming the start bit at its mid-point (sample 7)
//  S_DATA   | sampling 8 data bits LSB first at sample 15
//  S_PARITY | sampling the parity bit (PARITY_EN only)
//  S_STOP   | sampling the stop bit, completing the frame
module uart_rx #(
    parameter int DIV_WIDTH  = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rxIn,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [7:0]           dataOut,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 overrun,
    input  logic                 errClear
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] div_cnt, div_lat, div_act;
    logic                 tick;
    logic [3:0]           smp_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift;
    logic                 par_bad;

    logic start_det, start_mid, sample_pt, frame_done, frame_good;

    // The live divisor only paces idle-line polling; a frame runs on the latched copy.
    assign div_act = (state == S_IDLE) ? divisor : div_lat;
    assign tick    = (div_cnt >= div_act);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (tick && !rxIn) state_nxt = S_START;
            S_START:  if (tick && smp_cnt == 4'd7) state_nxt = rxIn ? S_IDLE : S_DATA;
            S_DATA: begin
                if (sample_pt && bit_cnt == 3'd7) begin
                    if (PARITY_EN) state_nxt = S_PARITY;
                    else           state_nxt = S_STOP;
                end
            end
            S_PARITY: if (sample_pt) state_nxt = S_STOP;
            S_STOP:   if (sample_pt) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_det  = (state == S_IDLE) && tick && !rxIn;
        start_mid  = (state == S_START) && tick && (smp_cnt == 4'd7);
        sample_pt  = tick && (smp_cnt == 4'd15) &&
                     ((state == S_DATA) || (state == S_PARITY) || (state == S_STOP));
        frame_done = sample_pt && (state == S_STOP);
        frame_good = frame_done && rxIn && !par_bad;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            div_lat <= '0;
            smp_cnt <= 4'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            par_bad <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
            if (start_det) begin
                div_lat <= divisor;
            end
            if (start_det || start_mid) begin
                smp_cnt <= 4'd0;
            end else if (tick && state != S_IDLE) begin
                smp_cnt <= smp_cnt + 4'd1;
            end
            if (start_det) begin
                bit_cnt <= 3'd0;
                par_bad <= 1'b0;
            end else if (sample_pt && state == S_DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {rxIn, shift[7:1]};
            end else if (sample_pt && state == S_PARITY) begin
                par_bad <= rxIn ^ (^shift) ^ PARITY_ODD;
            end
        end
    end

    // A completing good frame may refill the buffer in the same cycle it is consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dataOut   <= 8'h00;
            dataValid <= 1'b0;
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_good && (!dataValid || dataReady)) begin
                dataOut   <= shift;
                dataValid <= 1'b1;
            end else if (dataValid && dataReady) begin
                dataValid <= 1'b0;
            end
            frameErr  <= (frameErr  && !errClear) || (frame_done && !rxIn);
            parityErr <= (parityErr && !errClear) || (frame_done && par_bad);
            overrun   <= (overrun   && !errClear) || (frame_good && dataValid && !dataReady);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance; received bytes are
// checked against a queue of expected bytes as they are handshaken out.
module tb_uart_rx;

    logic        clk;
    logic        resetn_a, rx_a, dataReady_a, errClear_a;
    logic [15:0] divisor_a;
    logic [7:0]  dataOut_a;
    logic        dataValid_a, frameErr_a, parityErr_a, overrun_a;

    logic        resetn_b, rx_b, rdy_b, clr_b;
    logic [15:0] divisor_b;
    logic [7:0]  do_b;
    logic        dv_b, fe_b, pe_b, ov_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat;
    bit          auto_a;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         div;
        bit         good;
        int         gap;
    } vec_t;
    localparam int NV = 7;
    vec_t tbl[NV];

    uart_rx dut_a (
        .clk(clk), .resetn(resetn_a), .rxIn(rx_a), .divisor(divisor_a),
        .dataOut(dataOut_a), .dataValid(dataValid_a), .dataReady(dataReady_a),
        .frameErr(frameErr_a), .parityErr(parityErr_a), .overrun(overrun_a),
        .errClear(errClear_a)
    );

    uart_rx #(.DIV_WIDTH(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .clk(clk), .resetn(resetn_b), .rxIn(rx_b), .divisor(divisor_b),
        .dataOut(do_b), .dataValid(dv_b), .dataReady(rdy_b),
        .frameErr(fe_b), .parityErr(pe_b), .overrun(ov_b),
        .errClear(clr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit epar(input logic [7:0] d);
        return ^d;
    endfunction

    // Called at posedge+1; leaves the line at v for bl cycles.
    task automatic drive_bit(input bit sel, input logic v, input int bl);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (bl) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit stop,
                              input int div, input bit use_par, input bit par);
        int bl;
        bl = 16 * (div + 1);
        if (!sel) divisor_a = 16'(div);
        drive_bit(sel, 1'b0, bl);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], bl);
        if (use_par) drive_bit(sel, par, bl);
        drive_bit(sel, stop, bl);
        if (sel) rx_b = 1'b1;
        else     rx_a = 1'b1;
    endtask

    task automatic clear_a();
        errClear_a = 1'b1;
        @(posedge clk);
        #1;
        errClear_a = 1'b0;
    endtask

    // Consumers: acknowledge each valid byte once and compare it with the queue head.
    initial begin
        dataReady_a = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_a) begin
                if (dataValid_a && !dataReady_a) begin
                    if (qa.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_byte_a: got %0h expected none", dataOut_a);
                    end else begin
                        check("rx_byte_a", 32'(dataOut_a), 32'(qa.pop_front()));
                    end
                    dataReady_a = 1'b1;
                end else begin
                    dataReady_a = 1'b0;
                end
            end
        end
    end

    initial begin
        rdy_b = 1'b0;
        forever begin
            @(negedge clk);
            if (dv_b && !rdy_b) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_byte_b: got %0h expected none", do_b);
                end else begin
                    check("rx_byte_b", 32'(do_b), 32'(qb.pop_front()));
                end
                rdy_b = 1'b1;
            end else begin
                rdy_b = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 0, 1'b1, 2};
        tbl[1] = '{8'h3C, 1'b1, 3, 1'b1, 0};
        tbl[2] = '{8'hC3, 1'b1, 3, 1'b1, 2};
        tbl[3] = '{8'h55, 1'b0, 0, 1'b0, 2};
        tbl[4] = '{8'h00, 1'b1, 1, 1'b1, 2};
        tbl[5] = '{8'hFF, 1'b1, 2, 1'b1, 2};
        tbl[6] = '{8'h80, 1'b0, 1, 1'b0, 2};

        rx_a = 1'b1; rx_b = 1'b1; resetn_a = 1'b0; resetn_b = 1'b0;
        divisor_a = 16'd0; divisor_b = 16'd0; errClear_a = 1'b0; clr_b = 1'b0;
        auto_a = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_dataOut", 32'(dataOut_a), 32'h00);
        check("rst_dataValid", 32'(dataValid_a), 32'h0);
        check("rst_frameErr", 32'(frameErr_a), 32'h0);
        check("rst_parityErr", 32'(parityErr_a), 32'h0);
        check("rst_overrun", 32'(overrun_a), 32'h0);
        check("rst_dv_b", 32'(dv_b), 32'h0);
        resetn_a = 1'b1; resetn_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Latency, 8N1 at divisor 0.
        qa.push_back(8'hA5);
        lat = 0;
        fork
            send_frame(1'b0, 8'hA5, 1'b1, 0, 1'b0, 1'b0);
            begin
                do begin
                    @(posedge clk);
                    #1;
                    lat++;
                end while (!dataValid_a && lat < 400);
            end
        join
        check("latency_8n1", 32'(lat - 1), 32'd152);
        check("lat_flags", 32'({frameErr_a, parityErr_a, overrun_a}), 32'h0);
        drive_bit(1'b0, 1'b1, 32);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].good) qa.push_back(tbl[i].data);
            send_frame(1'b0, tbl[i].data, tbl[i].stop, tbl[i].div, 1'b0, 1'b0);
            if (tbl[i].gap > 0) drive_bit(1'b0, 1'b1, tbl[i].gap * 16 * (tbl[i].div + 1));
            check($sformatf("vec%0d_frameErr", i), 32'(frameErr_a), 32'(!tbl[i].good));
            check($sformatf("vec%0d_parityErr", i), 32'(parityErr_a), 32'h0);
            check($sformatf("vec%0d_overrun", i), 32'(overrun_a), 32'h0);
            if (!tbl[i].good) begin
                clear_a();
                check($sformatf("vec%0d_clear", i), 32'(frameErr_a), 32'h0);
            end
        end
        check("table_queue_empty", 32'(qa.size()), 32'd0);

        // Divisor changed mid-frame must not disturb the frame in flight.
        qa.push_back(8'h69);
        fork
            send_frame(1'b0, 8'h69, 1'b1, 2, 1'b0, 1'b0);
            begin
                repeat (100) @(posedge clk);
                #1;
                divisor_a = 16'd0;
            end
        join
        divisor_a = 16'd2;
        drive_bit(1'b0, 1'b1, 96);
        check("divchg_frameErr", 32'(frameErr_a), 32'h0);

        // Short low glitch: 4 ticks at divisor 0.
        divisor_a = 16'd0;
        drive_bit(1'b0, 1'b1, 4);
        drive_bit(1'b0, 1'b0, 4);
        drive_bit(1'b0, 1'b1, 40);
        check("glitch_valid", 32'(dataValid_a), 32'h0);
        check("glitch_flags", 32'({frameErr_a, parityErr_a, overrun_a}), 32'h0);

        // Stop error coinciding with errClear: the set wins.
        fork
            send_frame(1'b0, 8'h55, 1'b0, 0, 1'b0, 1'b0);
            begin
                repeat (152) @(posedge clk);
                #1;
                errClear_a = 1'b1;
                @(posedge clk);
                #1;
                errClear_a = 1'b0;
            end
        join
        drive_bit(1'b0, 1'b1, 32);
        check("clr_vs_set_frameErr", 32'(frameErr_a), 32'h1);
        check("clr_vs_set_valid", 32'(dataValid_a), 32'h0);
        clear_a();

        // Overrun and completion-cycle handshake, consumer driven by hand.
        auto_a = 1'b0;
        @(posedge clk);
        #1;
        dataReady_a = 1'b0;
        send_frame(1'b0, 8'h11, 1'b1, 0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 32);
        check("ovr_first_valid", 32'(dataValid_a), 32'h1);
        check("ovr_first_data", 32'(dataOut_a), 32'h11);
        send_frame(1'b0, 8'h22, 1'b1, 0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 32);
        check("ovr_set", 32'(overrun_a), 32'h1);
        check("ovr_data_held", 32'(dataOut_a), 32'h11);
        clear_a();
        check("ovr_cleared", 32'(overrun_a), 32'h0);
        fork
            send_frame(1'b0, 8'h22, 1'b1, 0, 1'b0, 1'b0);
            begin
                repeat (152) @(posedge clk);
                #1;
                dataReady_a = 1'b1;
                @(posedge clk);
                #1;
                dataReady_a = 1'b0;
            end
        join
        drive_bit(1'b0, 1'b1, 32);
        check("hs_same_cycle_data", 32'(dataOut_a), 32'h22);
        check("hs_same_cycle_valid", 32'(dataValid_a), 32'h1);
        check("hs_same_cycle_overrun", 32'(overrun_a), 32'h0);
        dataReady_a = 1'b1;
        @(posedge clk);
        #1;
        dataReady_a = 1'b0;
        check("hs_clear_valid", 32'(dataValid_a), 32'h0);
        check("hs_data_hold", 32'(dataOut_a), 32'h22);
        auto_a = 1'b1;

        // Parity instance: latency with parity, parity error, reset mid-frame.
        qb.push_back(8'h3B);
        lat = 0;
        fork
            send_frame(1'b1, 8'h3B, 1'b1, 0, 1'b1, epar(8'h3B));
            begin
                do begin
                    @(posedge clk);
                    #1;
                    lat++;
                end while (!dv_b && lat < 400);
            end
        join
        check("latency_8e1", 32'(lat - 1), 32'd168);
        drive_bit(1'b1, 1'b1, 32);
        check("par_good_flags", 32'({fe_b, pe_b, ov_b}), 32'h0);

        send_frame(1'b1, 8'h07, 1'b1, 0, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 32);
        check("par_err_set", 32'(pe_b), 32'h1);
        check("par_err_valid", 32'(dv_b), 32'h0);
        check("par_err_frameErr", 32'(fe_b), 32'h0);

        fork
            send_frame(1'b1, 8'h5A, 1'b1, 0, 1'b1, epar(8'h5A));
            begin
                repeat (60) @(posedge clk);
                #1;
                resetn_b = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("rstmid_outputs", 32'({do_b, dv_b, fe_b, pe_b, ov_b}), 32'h0);
                repeat (150) @(posedge clk);
                #1;
                resetn_b = 1'b1;
            end
        join
        drive_bit(1'b1, 1'b1, 64);
        check("rstmid_after_valid", 32'(dv_b), 32'h0);
        check("rstmid_after_flags", 32'({fe_b, pe_b, ov_b}), 32'h0);

        qb.push_back(8'h96);
        send_frame(1'b1, 8'h96, 1'b1, 0, 1'b1, epar(8'h96));
        drive_bit(1'b1, 1'b1, 32);
        check("post_rst_flags", 32'({fe_b, pe_b, ov_b}), 32'h0);

        repeat (50) @(posedge clk);
        #1;
        check("queue_a_empty", 32'(qa.size()), 32'd0);
        check("queue_b_empty", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
